// File: rtl/hazard_scoreboard_if.sv
// Hazard-unit bus: decode/execute/memory/writeback register tags in, forwarding
// selects and stall/flush controls out. The pipeline is the master, the scoreboard the slave.
interface hazard_scoreboard_if #(parameter int ADDR_W = 5);
    logic [ADDR_W-1:0] RS1D, RS2D, RS1E, RS2E, RdE, RdM, RdW;
    logic              McOpD, LoadE, PCSrcE, McStartE, RegwriteM, RegwriteW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, FlushD, FlushE, McBusy, McDone;

    modport master (
        output RS1D, RS2D, RS1E, RS2E, RdE, RdM, RdW,
        output McOpD, LoadE, PCSrcE, McStartE, RegwriteM, RegwriteW,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, McBusy, McDone
    );

    modport slave (
        input  RS1D, RS2D, RS1E, RS2E, RdE, RdM, RdW,
        input  McOpD, LoadE, PCSrcE, McStartE, RegwriteM, RegwriteW,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, McBusy, McDone
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and, when
// HAZARD_SCOREBOARD_MC_EN is defined, a multicycle-unit scoreboard (IDLE/RUN/DONE).
module hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int MC_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   hz
);

    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs, rd_m, rd_w,
                                           input logic we_m, we_w);
        if (we_m && rs != '0 && rs == rd_m)      return 2'b10;
        else if (we_w && rs != '0 && rs == rd_w) return 2'b01;
        else                                     return 2'b00;
    endfunction

    logic load_use, mc_stall, mc_busy, mc_done, hz_stall;

`ifdef HAZARD_SCOREBOARD_MC_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} mc_state_e;

    mc_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mc_rd_q, mc_rd_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_rd_d = mc_rd_q;
        case (state_q)
            IDLE: if (hz.McStartE) begin
                state_d = RUN;
                mc_rd_d = hz.RdE;
                cnt_d   = 4'(MC_LAT - 1);
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mc_rd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_rd_q <= mc_rd_d;
        end
    end

    // Destination-of-flight compare includes RdE so a younger write cannot overtake the unit.
    assign mc_busy  = (state_q != IDLE);
    assign mc_done  = (state_q == DONE);
    assign mc_stall = mc_busy && (hz.McOpD ||
                      (mc_rd_q != '0 && (hz.RS1D == mc_rd_q || hz.RS2D == mc_rd_q ||
                                         hz.RdE == mc_rd_q)));
`else
    wire unused_mc = &{1'b0, clk, hz.McOpD, hz.McStartE};
    assign mc_busy  = 1'b0;
    assign mc_done  = 1'b0;
    assign mc_stall = 1'b0;
`endif

    assign load_use = hz.LoadE && (hz.RdE != '0) && (hz.RdE == hz.RS1D || hz.RdE == hz.RS2D);
    assign hz_stall = load_use || mc_stall;

    // A taken branch squashes the stalled instruction anyway, so it wins over any stall.
    assign hz.StallF    = !rst && hz_stall && !hz.PCSrcE;
    assign hz.StallD    = !rst && hz_stall && !hz.PCSrcE;
    assign hz.FlushD    = !rst && hz.PCSrcE;
    assign hz.FlushE    = !rst && (hz_stall || hz.PCSrcE);
    assign hz.McBusy    = !rst && mc_busy;
    assign hz.McDone    = !rst && mc_done;
    assign hz.ForwardAE = rst ? 2'b00 : fwd_sel(hz.RS1E, hz.RdM, hz.RdW, hz.RegwriteM, hz.RegwriteW);
    assign hz.ForwardBE = rst ? 2'b00 : fwd_sel(hz.RS2E, hz.RdM, hz.RdW, hz.RegwriteM, hz.RegwriteW);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; multicycle checks follow HAZARD_SCOREBOARD_MC_EN.
module tb_hazard_scoreboard;
    localparam int ADDR_W = 5;
    localparam int MC_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    hazard_scoreboard_if #(.ADDR_W(ADDR_W)) hz ();

    hazard_scoreboard #(.ADDR_W(ADDR_W), .MC_LAT(MC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {StallF, StallD, FlushD, FlushE}
    function automatic logic [7:0] ctl();
        return {4'b0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    endfunction

    function automatic logic [7:0] mc();
        return {6'b0, hz.McBusy, hz.McDone};
    endfunction

    function automatic logic [7:0] fwd();
        return {4'b0, hz.ForwardAE, hz.ForwardBE};
    endfunction

    task automatic clr();
        hz.RS1D = '0; hz.RS2D = '0; hz.RS1E = '0; hz.RS2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.McOpD = 0; hz.LoadE = 0; hz.PCSrcE = 0; hz.McStartE = 0;
        hz.RegwriteM = 0; hz.RegwriteW = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        // reset masks outputs even with hazard-causing inputs present
        hz.LoadE = 1; hz.RdE = 7; hz.RS2D = 7; hz.PCSrcE = 1;
        hz.RS1E = 5; hz.RdM = 5; hz.RegwriteM = 1; hz.McStartE = 1;
        #2;
        chk("rst_ctl", ctl(), 8'h0);
        chk("rst_fwd", fwd(), 8'h0);
        chk("rst_mc",  mc(),  8'h0);
        step();
        rst = 1'b0;
        clr();
        #1;
        chk("idle_ctl", ctl(), 8'h0);
        chk("idle_mc",  mc(),  8'h0);

        // forwarding
        hz.RS1E = 5; hz.RdM = 5; hz.RegwriteM = 1; hz.RdW = 5; hz.RegwriteW = 1; hz.RS2E = 0;
        #1; chk("fwd_m_prio", fwd(), 8'b1000);
        hz.RegwriteM = 0;
        #1; chk("fwd_w", fwd(), 8'b0100);
        hz.RS1E = 4; hz.RdM = 4; hz.RegwriteM = 1; hz.RS2E = 3; hz.RdW = 3;
        #1; chk("fwd_a_m_b_w", fwd(), 8'b1001);
        hz.RS1E = 6; hz.RS2E = 0; hz.RdM = 0; hz.RdW = 0;
        #1; chk("fwd_none_zero", fwd(), 8'b0000);
        hz.RS2E = 3; hz.RdW = 3; hz.RegwriteW = 0;
        #1; chk("fwd_w_disabled", fwd(), 8'b0000);
        hz.LoadE = 1; hz.RdE = 3; hz.RS1D = 3;
        #1; chk("fwd_ignores_stall", fwd(), 8'b0000);
        clr();

        // load-use
        hz.LoadE = 1; hz.RdE = 7; hz.RS2D = 7;
        #1; chk("lu_stall", ctl(), 8'b1101);
        step();
        hz.LoadE = 0; hz.RdE = 0;
        #1; chk("lu_release", ctl(), 8'b0000);
        hz.LoadE = 1; hz.RdE = 0; hz.RS1D = 0;
        #1; chk("lu_x0", ctl(), 8'b0000);
        hz.RdE = 8; hz.RS1D = 8; hz.PCSrcE = 1;
        #1; chk("lu_branch", ctl(), 8'b0011);
        hz.LoadE = 0;
        #1; chk("branch_only", ctl(), 8'b0011);
        step();
        clr();

`ifdef HAZARD_SCOREBOARD_MC_EN
        // start at edge k, consumer of x9 in decode afterwards
        hz.McStartE = 1; hz.RdE = 9;
        #1; chk("mc_pre", mc(), 8'b00);
        for (int c = 1; c <= MC_LAT + 1; c++) begin
            step();
            clr();
            hz.RS1D = 9;
            #1;
            chk($sformatf("mc_state_c%0d", c), mc(),
                (c <= MC_LAT) ? {6'b0, 1'b1, c == MC_LAT} : 8'b00);
            chk($sformatf("mc_raw_c%0d", c), ctl(), (c <= MC_LAT) ? 8'b1101 : 8'b0000);
        end
        clr();

        // branch beats structural stall
        hz.McStartE = 1; hz.RdE = 9;
        step();
        clr();
        hz.McOpD = 1; hz.PCSrcE = 1;
        #1; chk("mc_branch", ctl(), 8'b0011);
        hz.PCSrcE = 0;
        #1; chk("mc_struct", ctl(), 8'b1101);
        hz.LoadE = 1; hz.RdE = 9; hz.RS1D = 9;
        #1; chk("mc_lu_combined", ctl(), 8'b1101);
        clr();
        // reset during run (cycle k+2) abandons the op
        step();
        rst = 1; hz.RS1D = 9;
        #1; chk("mc_rst_out", mc(), 8'b00);
        step();
        rst = 0;
        for (int c = 0; c < MC_LAT + 1; c++) begin
            #1;
            chk($sformatf("mc_abort_%0d", c), {mc()[1:0], ctl()[3:0]}, 8'h0);
            step();
        end
        clr();

        // x0 destination: full latency, no RAW stall
        hz.McStartE = 1; hz.RdE = 0;
        step();
        clr();
        #1; chk("mc_x0_busy", mc(), 8'b10);
        chk("mc_x0_nostall", ctl(), 8'b0000);
        for (int c = 2; c < MC_LAT; c++) step();
        step();
        #1; chk("mc_x0_done", mc(), 8'b01 | 8'b10);
        step();
        #1; chk("mc_x0_idle", mc(), 8'b00);
`else
        hz.McStartE = 1; hz.McOpD = 1; hz.RdE = 9; hz.RS1D = 9;
        #1; chk("nomc_issue", ctl(), 8'b0000);
        for (int c = 1; c <= MC_LAT + 1; c++) begin
            step();
            hz.McStartE = 0; hz.RdE = 0;
            #1;
            chk($sformatf("nomc_mc_c%0d", c), mc(), 8'b00);
            chk($sformatf("nomc_ctl_c%0d", c), ctl(), 8'b0000);
            hz.McStartE = 1;
        end
        clr();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter MC_LAT, default 4, multicycle-unit latency in cycles; legal range 2..16.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 RS1D, RS2D  in  ADDR_W  decode-stage source registers.
REQ-006 McOpD  in  1  decode-stage instruction is a multicycle op.
REQ-007 RS1E, RS2E, RdE  in  ADDR_W  execute-stage sources and destination.
REQ-008 LoadE  in  1  execute-stage instruction is a load.
REQ-009 PCSrcE  in  1  taken branch or jump resolved in execute.
REQ-010 McStartE  in  1  multicycle op issued from execute this cycle.
REQ-011 RdM, RdW  in  ADDR_W  memory/writeback destinations.
REQ-012 RegwriteM, RegwriteW  in  1  memory/writeback write enables.
REQ-013 ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 from W, 10 from M.
REQ-014 StallF, StallD  out  1  hold PC and IF/ID.
REQ-015 FlushD, FlushE  out  1  bubble IF/ID and ID/EX.
REQ-016 McBusy  out  1  multicycle unit occupied (state != IDLE).
REQ-017 McDone  out  1  one-cycle pulse; result written via dedicated regfile port.

Function
REQ-018 ForwardXE = 10 when RSXE==RdM, RegwriteM=1, RSXE!=0; else 01 when RSXE==RdW, RegwriteW=1, RSXE!=0; else 00; M has priority over W.
REQ-019 Load-use: LoadE=1, RdE!=0, RdE equals RS1D or RS2D -> StallF=StallD=FlushE=1 for exactly one cycle.
REQ-020 Branch: PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0; overrides every stall condition in the same cycle.
REQ-021 Multicycle FSM states IDLE, RUN, DONE; pending register McRd (ADDR_W) and counter Cnt (4 bits).
REQ-022 IDLE + McStartE=1 -> RUN; McRd<=RdE; Cnt<=MC_LAT-1.
REQ-023 RUN: Cnt decrements each cycle; on Cnt==1 -> DONE.
REQ-024 DONE: McDone=1 for one cycle -> IDLE; McDone rises exactly MC_LAT cycles after the McStartE edge.
REQ-025 McStartE in RUN or DONE is ignored (prevented upstream by REQ-027).
REQ-026 RAW: state!=IDLE, McRd!=0, RS1D or RS2D or RdE equals McRd -> StallF=StallD=FlushE=1; released the cycle after DONE.
REQ-027 Structural: McOpD=1 and state!=IDLE -> StallF=StallD=FlushE=1.
REQ-028 McRd==0 never causes a RAW stall; the FSM still runs for the full latency.
REQ-029 Load-use and multicycle stalls coincident -> single combined stall; no double bubble.
REQ-030 Forwarding outputs are combinational and unaffected by stall/flush state.

Reset
REQ-031 rst=1 at a clock edge -> state IDLE, Cnt=0, McRd=0.
REQ-032 During reset, all outputs = 0, ForwardAE/BE=00.
REQ-033 Reset mid-RUN abandons the op; McDone not asserted afterwards.

Configuration
REQ-034 Macro HAZARD_SCOREBOARD_MC_EN defined: multicycle FSM, REQ-021..REQ-029 and REQ-033 present.
REQ-035 Macro HAZARD_SCOREBOARD_MC_EN undefined: no FSM state; McOpD/McStartE ignored; McBusy=McDone=0; forwarding, load-use and branch unchanged.

Verification
REQ-036 RS1E=5, RdM=5, RegwriteM=1, RdW=5, RegwriteW=1 -> ForwardAE=10; RS2E=0, RdM=0 -> ForwardBE=00.
REQ-037 LoadE=1, RdE=7, RS2D=7 -> one cycle StallF=StallD=FlushE=1, then all 0.
REQ-038 MC_LAT=4, McStartE=1, RdE=9 at edge k -> McBusy 1 from k+1; McDone=1 only in cycle k+4; RS1D=9 stalled through k+4, released k+5.
REQ-039 McBusy=1, McOpD=1, PCSrcE=1 same cycle -> StallF=StallD=0, FlushD=FlushE=1.
REQ-040 rst=1 in cycle k+2 of REQ-038 run -> IDLE at next edge, McDone never pulses, stalls drop.
REQ-041 Macro undefined, McStartE=1 -> McBusy=McDone=0, no stall.
